// File: rtl/tx_pattern_src.sv
// Transmit pattern source: one parallel Fibonacci LFSR (PRBS7/15/23/31), clock or
// user word, with polarity inversion and single-bit error injection on dout[0].
module tx_pattern_src #(
    parameter int unsigned N_LANES   = 16,
    parameter int unsigned ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cke,
    input  logic [2:0]           mode,
    input  logic [N_LANES-1:0]   user_pat,
    input  logic                 inv,
    input  logic                 inj_err,
    output logic [N_LANES-1:0]   dout,
    output logic [N_LANES-1:0]   dout_b,
    output logic                 valid,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [30:0]          lfsr_state
);

    typedef enum logic {ST_SEED, ST_RUN} state_t;

    typedef struct packed {
        logic [30:0]        state;
        logic [N_LANES-1:0] word;
    } adv_t;

    // N_LANES unrolled steps; umask keeps the unused upper state bits at 1.
    function automatic adv_t prbs_adv(input logic [30:0] seed, input logic [4:0] msb,
                                      input logic [4:0] tap, input logic [30:0] umask);
        adv_t        r;
        logic [30:0] s;
        logic        nb;
        s      = seed;
        r.word = '0;
        for (int unsigned k = 0; k < N_LANES; k++) begin
            r.word[k] = s[msb];
            nb        = s[msb] ^ s[tap];
            s         = {s[29:0], nb} | umask;
        end
        r.state = s;
        return r;
    endfunction

    state_t             r_state;
    logic [2:0]         r_mode_q;
    logic               r_inj_q;
    logic               r_pending;
    logic [30:0]        r_lfsr;
    logic [N_LANES-1:0] r_dout;
    logic [N_LANES-1:0] r_dout_b;
    logic               r_valid;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    adv_t               w_adv7;
    adv_t               w_adv15;
    adv_t               w_adv23;
    adv_t               w_adv31;
    logic [2:0]         w_mode_eff;
    logic [N_LANES-1:0] w_clk_pat;
    logic [N_LANES-1:0] w_pat;
    logic [N_LANES-1:0] w_word;
    logic [30:0]        w_lfsr_nxt;
    logic               w_edge;

    assign w_edge     = inj_err & ~r_inj_q;
    assign w_mode_eff = (r_mode_q > 3'd5) ? 3'd0 : r_mode_q;

    always_comb begin
        w_adv7     = prbs_adv(r_lfsr, 5'd6,  5'd5,  31'h7FFF_FF80);
        w_adv15    = prbs_adv(r_lfsr, 5'd14, 5'd13, 31'h7FFF_8000);
        w_adv23    = prbs_adv(r_lfsr, 5'd22, 5'd17, 31'h7F80_0000);
        w_adv31    = prbs_adv(r_lfsr, 5'd30, 5'd27, 31'h0000_0000);
        w_clk_pat  = '0;
        for (int unsigned k = 0; k < N_LANES; k++) begin
            w_clk_pat[k] = ((k % 2) == 0);
        end
        w_pat      = w_adv7.word;
        w_lfsr_nxt = w_adv7.state;
        case (w_mode_eff)
            3'd1: begin
                w_pat      = w_adv15.word;
                w_lfsr_nxt = w_adv15.state;
            end
            3'd2: begin
                w_pat      = w_adv23.word;
                w_lfsr_nxt = w_adv23.state;
            end
            3'd3: begin
                w_pat      = w_adv31.word;
                w_lfsr_nxt = w_adv31.state;
            end
            3'd4: begin
                w_pat      = w_clk_pat;
                w_lfsr_nxt = r_lfsr;
            end
            3'd5: begin
                w_pat      = user_pat;
                w_lfsr_nxt = r_lfsr;
            end
            default: begin
                w_pat      = w_adv7.word;
                w_lfsr_nxt = w_adv7.state;
            end
        endcase
        // Inversion first, then the injected flip on the earliest bit.
        w_word = w_pat ^ {N_LANES{inv}} ^ N_LANES'(r_pending);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_SEED;
            r_mode_q  <= '0;
            r_inj_q   <= 1'b0;
            r_pending <= 1'b0;
            r_lfsr    <= '1;
            r_dout    <= '0;
            r_dout_b  <= '1;
            r_valid   <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_inj_q <= inj_err;
            if (!cke) begin
                if (w_edge) r_pending <= 1'b1;
            end else if (mode != r_mode_q) begin
                r_mode_q <= mode;
                r_state  <= ST_SEED;
                r_valid  <= 1'b0;
                if (w_edge) r_pending <= 1'b1;
            end else begin
                case (r_state)
                    ST_SEED: begin
                        r_lfsr    <= '1;
                        r_valid   <= 1'b0;
                        // Stale requests are discarded; a fresh edge this cycle still arms.
                        r_pending <= w_edge;
                        r_state   <= ST_RUN;
                    end
                    ST_RUN: begin
                        r_lfsr   <= w_lfsr_nxt;
                        r_dout   <= w_word;
                        r_dout_b <= ~w_word;
                        r_valid  <= 1'b1;
                        if (r_pending) begin
                            r_pending <= 1'b0;
                            if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
                        end else begin
                            r_pending <= w_edge;
                        end
                    end
                endcase
            end
        end
    end

    assign dout       = r_dout;
    assign dout_b     = r_dout_b;
    assign valid      = r_valid;
    assign err_cnt    = r_err_cnt;
    assign lfsr_state = r_lfsr;

endmodule

// File: tb/tb_tx_pattern_src.sv
// Bench for tx_pattern_src: PRBS words from a bit-recurrence model, plus
// clock/user modes, mode switching, cke hold, error injection and saturation.
module tb_tx_pattern_src;

    logic        clk = 1'b0;
    logic        rst, cke, inv, inj_err;
    logic [2:0]  mode;
    logic [15:0] user_pat;
    logic [15:0] dout, dout_b;
    logic        valid;
    logic [15:0] err_cnt;
    logic [30:0] lfsr_state;

    logic        rst2, cke2, inv2, inj2;
    logic [2:0]  mode2;
    logic [15:0] user2;
    logic [15:0] dout2, dout2_b;
    logic        valid2;
    logic [1:0]  err2;
    logic [30:0] lfsr2;

    int          n_checks = 0;
    int          n_errs   = 0;
    logic [15:0] ec;

    // PRBS model: b[n] = b[n-L] ^ b[n-T], first L bits all ones.
    bit          m_seq[$];
    int          m_pos, m_len, m_tap;

    always #5 clk = ~clk;

    tx_pattern_src #(.N_LANES(16), .ERR_CNT_W(16)) dut (
        .clk(clk), .rst(rst), .cke(cke), .mode(mode), .user_pat(user_pat), .inv(inv),
        .inj_err(inj_err), .dout(dout), .dout_b(dout_b), .valid(valid),
        .err_cnt(err_cnt), .lfsr_state(lfsr_state)
    );

    tx_pattern_src #(.N_LANES(16), .ERR_CNT_W(2)) dut2 (
        .clk(clk), .rst(rst2), .cke(cke2), .mode(mode2), .user_pat(user2), .inv(inv2),
        .inj_err(inj2), .dout(dout2), .dout_b(dout2_b), .valid(valid2),
        .err_cnt(err2), .lfsr_state(lfsr2)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "timeout");
    end

    function automatic void mdl_seed(int len, int tap);
        m_seq.delete();
        for (int i = 0; i < len; i++) m_seq.push_back(1'b1);
        m_pos = 0;
        m_len = len;
        m_tap = tap;
    endfunction

    function automatic void mdl_fill(int idx);
        while (m_seq.size() <= idx)
            m_seq.push_back(m_seq[m_seq.size() - m_len] ^ m_seq[m_seq.size() - m_tap]);
    endfunction

    function automatic logic [15:0] mdl_word();
        logic [15:0] w;
        for (int k = 0; k < 16; k++) begin
            mdl_fill(m_pos);
            w[k] = m_seq[m_pos];
            m_pos++;
        end
        return w;
    endfunction

    // Register bit j holds the bit that leaves the shifter L-1-j steps from now.
    function automatic logic [30:0] mdl_state();
        logic [30:0] st;
        st = '1;
        for (int j = 0; j < m_len; j++) begin
            mdl_fill(m_pos + m_len - 1 - j);
            st[j] = m_seq[m_pos + m_len - 1 - j];
        end
        return st;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [15:0] e_w;
        rst = 1; cke = 1; mode = 0; inv = 0; inj_err = 0; user_pat = 16'h0;
        tick(); tick();
        n_checks++; if (dout !== 16'h0000) begin n_errs++; $display("FAIL rst_dout: got %h want 0000", dout); end
        n_checks++; if (dout_b !== 16'hFFFF) begin n_errs++; $display("FAIL rst_dout_b: got %h want FFFF", dout_b); end
        n_checks++; if (valid !== 1'b0) begin n_errs++; $display("FAIL rst_valid: got %b want 0", valid); end
        n_checks++; if (err_cnt !== 16'h0) begin n_errs++; $display("FAIL rst_err_cnt: got %h want 0", err_cnt); end
        n_checks++; if (lfsr_state !== 31'h7FFFFFFF) begin n_errs++; $display("FAIL rst_lfsr: got %h want 7fffffff", lfsr_state); end
        ec = 0;
        rst = 0;
        mdl_seed(7, 6);
        tick();
        n_checks++; if (valid !== 1'b0) begin n_errs++; $display("FAIL seed_valid: got %b want 0", valid); end
        tick();
        e_w = mdl_word();
        n_checks++; if (valid !== 1'b1) begin n_errs++; $display("FAIL first_valid: got %b want 1", valid); end
        n_checks++; if (dout !== 16'h207F) begin n_errs++; $display("FAIL first_word: got %h want 207F", dout); end
        n_checks++; if (dout !== e_w) begin n_errs++; $display("FAIL first_word_model: got %h want %h", dout, e_w); end
        n_checks++; if (dout_b !== 16'hDF80) begin n_errs++; $display("FAIL first_word_b: got %h want DF80", dout_b); end
        n_checks++; if (lfsr_state !== mdl_state()) begin n_errs++; $display("FAIL first_lfsr: got %h want %h", lfsr_state, mdl_state()); end
    endtask

    task automatic test_prbs7();
        logic [15:0] e_w;
        bit          dbits[$];
        int          bad;
        for (int i = 0; i < 16; i++) begin
            tick();
            e_w = mdl_word();
            n_checks++; if (dout !== e_w) begin n_errs++; $display("FAIL prbs7_word[%0d]: got %h want %h", i, dout, e_w); end
            n_checks++; if (dout_b !== ~e_w) begin n_errs++; $display("FAIL prbs7_word_b[%0d]: got %h want %h", i, dout_b, ~e_w); end
            n_checks++; if (lfsr_state !== mdl_state()) begin n_errs++; $display("FAIL prbs7_lfsr[%0d]: got %h want %h", i, lfsr_state, mdl_state()); end
            for (int k = 0; k < 16; k++) dbits.push_back(dout[k]);
        end
        bad = 0;
        for (int i = 0; i + 127 < dbits.size(); i++) if (dbits[i] != dbits[i + 127]) bad++;
        n_checks++; if (bad !== 0) begin n_errs++; $display("FAIL prbs7_period: %0d bits differ from 127 later, want 0", bad); end
    endtask

    task automatic test_inject();
        logic [15:0] e_w;
        rst = 1;
        tick();
        rst = 0; inj_err = 1; ec = 0;
        mdl_seed(7, 6);
        tick();
        n_checks++; if (valid !== 1'b0) begin n_errs++; $display("FAIL inj_seed_valid: got %b want 0", valid); end
        inj_err = 0;
        tick();
        e_w = mdl_word() ^ 16'h0001;
        ec++;
        n_checks++; if (dout !== 16'h207E) begin n_errs++; $display("FAIL inj_first: got %h want 207E", dout); end
        n_checks++; if (dout_b !== ~e_w) begin n_errs++; $display("FAIL inj_first_b: got %h want %h", dout_b, ~e_w); end
        n_checks++; if (err_cnt !== ec) begin n_errs++; $display("FAIL inj_first_cnt: got %0d want %0d", err_cnt, ec); end
        for (int i = 0; i < 4; i++) begin
            tick();
            e_w = mdl_word();
            n_checks++; if (dout !== e_w) begin n_errs++; $display("FAIL inj_after[%0d]: got %h want %h", i, dout, e_w); end
        end
        inj_err = 1;
        tick();
        e_w = mdl_word();
        n_checks++; if (dout !== e_w) begin n_errs++; $display("FAIL inj_arm_word: got %h want %h", dout, e_w); end
        inj_err = 0;
        tick();
        e_w = mdl_word() ^ 16'h0001;
        ec++;
        n_checks++; if (dout !== e_w) begin n_errs++; $display("FAIL inj_mid_word: got %h want %h", dout, e_w); end
        n_checks++; if (err_cnt !== ec) begin n_errs++; $display("FAIL inj_mid_cnt: got %0d want %0d", err_cnt, ec); end
        tick();
        e_w = mdl_word();
        n_checks++; if (dout !== e_w) begin n_errs++; $display("FAIL inj_resume: got %h want %h", dout, e_w); end
    endtask

    task automatic test_mode_switch();
        logic [15:0] prev;
        prev = mdl_word();
        m_pos -= 16;
        tick();
        prev = mdl_word();
        n_checks++; if (dout !== prev) begin n_errs++; $display("FAIL sw_pre: got %h want %h", dout, prev); end
        mode = 4;
        tick();
        n_checks++; if (valid !== 1'b0) begin n_errs++; $display("FAIL sw_chg_valid: got %b want 0", valid); end
        n_checks++; if (dout !== prev) begin n_errs++; $display("FAIL sw_chg_hold: got %h want %h", dout, prev); end
        tick();
        n_checks++; if (valid !== 1'b0) begin n_errs++; $display("FAIL sw_seed_valid: got %b want 0", valid); end
        n_checks++; if (dout !== prev) begin n_errs++; $display("FAIL sw_seed_hold: got %h want %h", dout, prev); end
        n_checks++; if (lfsr_state !== 31'h7FFFFFFF) begin n_errs++; $display("FAIL sw_seed_lfsr: got %h want 7fffffff", lfsr_state); end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if (dout !== 16'h5555 || valid !== 1'b1) begin n_errs++; $display("FAIL clk_word[%0d]: got %h/%b want 5555/1", i, dout, valid); end
            n_checks++; if (lfsr_state !== 31'h7FFFFFFF) begin n_errs++; $display("FAIL clk_lfsr[%0d]: got %h want 7fffffff", i, lfsr_state); end
        end
        inv = 1;
        tick();
        n_checks++; if (dout !== 16'hAAAA) begin n_errs++; $display("FAIL clk_inv: got %h want AAAA", dout); end
        n_checks++; if (dout_b !== 16'h5555) begin n_errs++; $display("FAIL clk_inv_b: got %h want 5555", dout_b); end
        inv = 0;
        tick();
        n_checks++; if (dout !== 16'h5555) begin n_errs++; $display("FAIL clk_uninv: got %h want 5555", dout); end
    endtask

    task automatic test_user();
        logic [15:0] up;
        logic        v;
        user_pat = 16'hF0F0; mode = 5;
        tick(); tick(); tick();
        n_checks++; if (dout !== 16'hF0F0 || valid !== 1'b1) begin n_errs++; $display("FAIL user_first: got %h/%b want F0F0/1", dout, valid); end
        cke = 0;
        inj_err = 1; tick();
        n_checks++; if (dout !== 16'hF0F0) begin n_errs++; $display("FAIL user_cke_hold: got %h want F0F0", dout); end
        inj_err = 0; tick();
        inj_err = 1; tick();
        inj_err = 0; tick(); tick();
        n_checks++; if (err_cnt !== ec) begin n_errs++; $display("FAIL user_cnt_held: got %0d want %0d", err_cnt, ec); end
        cke = 1;
        tick();
        ec++;
        n_checks++; if (dout !== 16'hF0F1) begin n_errs++; $display("FAIL user_inj: got %h want F0F1", dout); end
        n_checks++; if (err_cnt !== ec) begin n_errs++; $display("FAIL user_inj_cnt: got %0d want %0d", err_cnt, ec); end
        tick();
        n_checks++; if (dout !== 16'hF0F0) begin n_errs++; $display("FAIL user_after: got %h want F0F0", dout); end
        for (int i = 0; i < 5; i++) begin
            up = 16'($urandom);
            v  = 1'($urandom);
            user_pat = up; inv = v;
            tick();
            n_checks++; if (dout !== (up ^ {16{v}}) || valid !== 1'b1) begin n_errs++; $display("FAIL user_rand[%0d]: got %h/%b want %h/1", i, dout, valid, up ^ {16{v}}); end
        end
        inv = 0;
    endtask

    task automatic test_prbs31_cke();
        logic [15:0] e_w, held;
        logic [30:0] hs;
        logic        v;
        mode = 3;
        tick(); tick();
        mdl_seed(31, 28);
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                held = e_w; hs = mdl_state();
                cke = 0;
                for (int h = 0; h < 5; h++) begin
                    inv = 1'($urandom);
                    tick();
                    n_checks++; if (dout !== held) begin n_errs++; $display("FAIL p31_hold_dout[%0d]: got %h want %h", h, dout, held); end
                    n_checks++; if (lfsr_state !== hs) begin n_errs++; $display("FAIL p31_hold_lfsr[%0d]: got %h want %h", h, lfsr_state, hs); end
                end
                cke = 1;
            end
            v = 1'($urandom);
            inv = v;
            tick();
            e_w = mdl_word() ^ {16{v}};
            n_checks++; if (dout !== e_w) begin n_errs++; $display("FAIL p31_word[%0d]: got %h want %h", i, dout, e_w); end
            n_checks++; if (lfsr_state !== mdl_state()) begin n_errs++; $display("FAIL p31_lfsr[%0d]: got %h want %h", i, lfsr_state, mdl_state()); end
        end
        inv = 0;
    endtask

    task automatic test_random_inject();
        logic [15:0] e_w, held;
        logic        c, j, v, prev, rise, pend;
        mode = 1;
        tick(); tick();
        mdl_seed(15, 14);
        prev = 0; pend = 0; held = 16'h0;
        for (int i = 0; i < 80; i++) begin
            c = (i == 0) ? 1'b1 : ($urandom_range(3) != 0);
            j = ($urandom_range(2) == 0);
            v = 1'($urandom);
            cke = c; inj_err = j; inv = v;
            rise = j & ~prev;
            prev = j;
            if (c) begin
                e_w = mdl_word() ^ {16{v}} ^ {15'd0, pend};
                if (pend) begin
                    if (ec != 16'hFFFF) ec++;
                    pend = 0;
                end else begin
                    pend = rise;
                end
            end else begin
                e_w = held;
                pend = pend | rise;
            end
            held = e_w;
            tick();
            n_checks++; if (dout !== e_w || dout_b !== ~e_w) begin n_errs++; $display("FAIL rnd_word[%0d]: got %h/%h want %h/%h", i, dout, dout_b, e_w, ~e_w); end
            n_checks++; if (err_cnt !== ec) begin n_errs++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", i, err_cnt, ec); end
        end
        cke = 1; inj_err = 0; inv = 0;
    endtask

    task automatic test_reserved_mode();
        mode = 6;
        tick(); tick(); tick();
        n_checks++; if (dout !== 16'h207F || valid !== 1'b1) begin n_errs++; $display("FAIL mode6_word: got %h/%b want 207F/1", dout, valid); end
        n_checks++; if (err_cnt !== ec) begin n_errs++; $display("FAIL mode6_cnt: got %0d want %0d", err_cnt, ec); end
    endtask

    task automatic test_rst_mid();
        rst = 1;
        tick();
        ec = 0;
        n_checks++; if (dout !== 16'h0 || dout_b !== 16'hFFFF) begin n_errs++; $display("FAIL rstmid_dout: got %h/%h want 0000/FFFF", dout, dout_b); end
        n_checks++; if (valid !== 1'b0 || err_cnt !== ec) begin n_errs++; $display("FAIL rstmid_state: got valid %b cnt %0d want 0/0", valid, err_cnt); end
        n_checks++; if (lfsr_state !== 31'h7FFFFFFF) begin n_errs++; $display("FAIL rstmid_lfsr: got %h want 7fffffff", lfsr_state); end
        rst = 0;
    endtask

    task automatic test_errcnt_sat();
        logic [1:0] e;
        rst2 = 1;
        tick();
        n_checks++; if (err2 !== 2'd0) begin n_errs++; $display("FAIL sat_rst: got %0d want 0", err2); end
        rst2 = 0;
        tick(); tick();
        for (int p = 0; p < 5; p++) begin
            inj2 = 1; tick();
            inj2 = 0; tick(); tick();
            e = (p + 1 > 3) ? 2'd3 : 2'(p + 1);
            n_checks++; if (err2 !== e) begin n_errs++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", p, err2, e); end
        end
    endtask

    initial begin
        rst2 = 1; cke2 = 1; inv2 = 0; inj2 = 0; mode2 = 0; user2 = 16'h0;
        test_reset();
        test_prbs7();
        test_inject();
        test_mode_switch();
        test_user();
        test_prbs31_cke();
        test_random_inject();
        test_reserved_mode();
        test_rst_mid();
        test_errcnt_sat();
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
